lcd_register_display: RTL

Drives the Spartan3E starter-kit character LCD (HD44780-compatible, 4-bit mode, write-only) so the pipeline state can be inspected one step at a time. It sits downstream of the pipeline in the top level and consumes the value of the register selected by the `RegisterIndex` switches. It renders `R<idx>=<8 hex digits>` on line 1 and, optionally, the current PC on line 2. It runs from the scaled system clock and owns the `LCDE`/`LCDRS`/`LCDRW`/`LCDAT` pins.

---
 rtl/lcd_register_display.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_register_display.sv
// lcd_register_display
// Drives an HD44780-compatible character LCD in 4-bit write-only mode.
// Line 1 shows "R<idx>=<8 hex digits>" for the selected register. When the
// LCD_SECOND_LINE_EN macro is defined, line 2 shows "PC=<8 hex digits>".
//
// Ports
//   clock    system clock, all logic on posedge
//   reset    asynchronous active-low reset
//   refresh  single-cycle redraw request
//   index    register number shown after 'R'
//   value    register contents
//   pc       program counter (line 2 only, ignored otherwise)
//   busy     high from reset until the first frame is drawn and during frames
//   LCDE     LCD enable strobe
//   LCDRS    0 = command, 1 = data
//   LCDRW    tied low
//   LCDAT    data nibble
//
// state     | meaning
// ----------+-----------------------------------------------------------
// POWERUP   | waiting for the panel to power up after reset
// INIT      | four single-nibble writes that force 4-bit mode
// CONFIG    | function set, entry mode, display on, clear
// FRAME     | snapshot the inputs, then write the line(s)
// IDLE      | display up to date, waiting for refresh
//
// Inside INIT/CONFIG/FRAME the phase register walks each nibble through
// setup -> enable pulse -> hold, then the post-write wait.

`timescale 1ns/1ps

module lcd_register_display #(
   parameter int POWERUP_CYCLES    = 15000,
   parameter int INIT_WAIT_CYCLES  = 4100,
   parameter int E_PULSE_CYCLES    = 12,
   parameter int CMD_WAIT_CYCLES   = 40,
   parameter int CLEAR_WAIT_CYCLES = 1640
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        refresh,
   input  logic [3:0]  index,
   input  logic [31:0] value,
   input  logic [31:0] pc,
   output logic        busy,
   output logic        LCDE,
   output logic        LCDRS,
   output logic        LCDRW,
   output logic [3:0]  LCDAT
);

   localparam int MAX_A   = (POWERUP_CYCLES > INIT_WAIT_CYCLES) ? POWERUP_CYCLES : INIT_WAIT_CYCLES;
   localparam int MAX_B   = (MAX_A > CLEAR_WAIT_CYCLES) ? MAX_A : CLEAR_WAIT_CYCLES;
   localparam int MAX_C   = (MAX_B > CMD_WAIT_CYCLES) ? MAX_B : CMD_WAIT_CYCLES;
   localparam int CNT_MAX = (MAX_C > E_PULSE_CYCLES) ? MAX_C : E_PULSE_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

`ifdef LCD_SECOND_LINE_EN
   localparam int FRAME_BYTES = 24;
`else
   localparam int FRAME_BYTES = 12;
`endif
   localparam logic [4:0] LAST_FRAME_STEP = 5'(FRAME_BYTES - 1);

   typedef enum logic [2:0] {ST_POWERUP, ST_INIT, ST_CONFIG, ST_FRAME, ST_IDLE} state_t;
   typedef enum logic [2:0] {PH_SNAP, PH_SETUP, PH_PULSE, PH_HOLD, PH_WAIT} phase_t;

   state_t             state;
   phase_t             phase;
   logic [4:0]         step;
   logic               second;
   logic [CNT_W-1:0]   cnt;
   logic               pending;
   logic [3:0]         snap_index;
   logic [31:0]        snap_value;
`ifdef LCD_SECOND_LINE_EN
   logic [31:0]        snap_pc;
`else
   logic               unused_pc;
   assign unused_pc = ^pc;
`endif

   logic               single;
   logic               item_last;
   logic               item_done;
   int                 item_wait;
   logic [4:0]         step_inc;

   assign LCDRW = 1'b0;

   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   // {rs, byte} for item stp of state st; frame items read the snapshot
   function automatic logic [8:0] item_word(input state_t st, input logic [4:0] stp);
      logic [8:0] w;
      logic [2:0] d;
      logic [4:0] base;
      w = '0;
      d = stp[2:0] - 3'd4;
      base = {3'd7 - d, 2'b00};
      case (st)
         ST_INIT:   w = {1'b0, (stp == 5'd3) ? 8'h02 : 8'h03};
         ST_CONFIG: begin
            case (stp[1:0])
               2'd0:    w = {1'b0, 8'h28};
               2'd1:    w = {1'b0, 8'h06};
               2'd2:    w = {1'b0, 8'h0C};
               default: w = {1'b0, 8'h01};
            endcase
         end
         ST_FRAME: begin
            if (stp == 5'd0)       w = {1'b0, 8'h80};
            else if (stp == 5'd1)  w = {1'b1, 8'h52};
            else if (stp == 5'd2)  w = {1'b1, hex_ascii(snap_index)};
            else if (stp == 5'd3)  w = {1'b1, 8'h3D};
            else if (stp <= 5'd11) w = {1'b1, hex_ascii(snap_value[base +: 4])};
`ifdef LCD_SECOND_LINE_EN
            else if (stp == 5'd12) w = {1'b0, 8'hC0};
            else if (stp == 5'd13) w = {1'b1, 8'h50};
            else if (stp == 5'd14) w = {1'b1, 8'h43};
            else if (stp == 5'd15) w = {1'b1, 8'h3D};
            else begin
               base = {3'd7 - stp[2:0], 2'b00};
               w = {1'b1, hex_ascii(snap_pc[base +: 4])};
            end
`endif
         end
         default:   w = '0;
      endcase
      return w;
   endfunction

   // {rs, nibble}: init items are single low-nibble writes, bytes go high first
   function automatic logic [4:0] nibble_of(input state_t st, input logic [4:0] stp,
                                            input logic low);
      logic [8:0] w;
      w = item_word(st, stp);
      return {w[8], (low || st == ST_INIT) ? w[3:0] : w[7:4]};
   endfunction

   always_comb begin
      single    = (state == ST_INIT);
      step_inc  = step + 5'd1;
      item_wait = CMD_WAIT_CYCLES;
      if (state == ST_INIT)
         item_wait = INIT_WAIT_CYCLES;
      else if (state == ST_CONFIG && step == 5'd3)
         item_wait = CLEAR_WAIT_CYCLES;
      if (state == ST_FRAME)
         item_last = (step == LAST_FRAME_STEP);
      else
         item_last = (step == 5'd3);
      item_done = ((phase == PH_HOLD) && (single || second) && (item_wait == 0)) ||
                  ((phase == PH_WAIT) && (cnt == '0));
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= ST_POWERUP;
         phase      <= PH_SNAP;
         step       <= '0;
         second     <= 1'b0;
         cnt        <= CNT_W'(POWERUP_CYCLES - 1);
         pending    <= 1'b0;
         busy       <= 1'b1;
         LCDE       <= 1'b0;
         LCDRS      <= 1'b0;
         LCDAT      <= '0;
         snap_index <= '0;
         snap_value <= '0;
`ifdef LCD_SECOND_LINE_EN
         snap_pc    <= '0;
`endif
      end else begin
         if (refresh && state != ST_IDLE)
            pending <= 1'b1;

         if (state == ST_POWERUP) begin
            if (cnt == '0) begin
               state          <= ST_INIT;
               step           <= '0;
               phase          <= PH_SETUP;
               second         <= 1'b0;
               {LCDRS, LCDAT} <= nibble_of(ST_INIT, 5'd0, 1'b0);
            end else begin
               cnt <= cnt - CNT_W'(1);
            end
         end else if (state == ST_IDLE) begin
            if (refresh) begin
               state <= ST_FRAME;
               phase <= PH_SNAP;
               busy  <= 1'b1;
            end
         end else if (item_done) begin
            if (!item_last) begin
               step           <= step_inc;
               phase          <= PH_SETUP;
               second         <= 1'b0;
               {LCDRS, LCDAT} <= nibble_of(state, step_inc, 1'b0);
            end else begin
               case (state)
                  ST_INIT: begin
                     state          <= ST_CONFIG;
                     step           <= '0;
                     phase          <= PH_SETUP;
                     second         <= 1'b0;
                     {LCDRS, LCDAT} <= nibble_of(ST_CONFIG, 5'd0, 1'b0);
                  end
                  ST_CONFIG: begin
                     state <= ST_FRAME;
                     phase <= PH_SNAP;
                  end
                  default: begin
                     // a request seen during the frame (or on its last cycle)
                     // chains straight into the next frame without idling
                     if (pending || refresh) begin
                        pending <= 1'b0;
                        phase   <= PH_SNAP;
                     end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                     end
                  end
               endcase
            end
         end else begin
            case (phase)
               PH_SNAP: begin
                  snap_index     <= index;
                  snap_value     <= value;
`ifdef LCD_SECOND_LINE_EN
                  snap_pc        <= pc;
`endif
                  step           <= '0;
                  phase          <= PH_SETUP;
                  second         <= 1'b0;
                  {LCDRS, LCDAT} <= nibble_of(ST_FRAME, 5'd0, 1'b0);
               end
               PH_SETUP: begin
                  LCDE  <= 1'b1;
                  cnt   <= CNT_W'(E_PULSE_CYCLES - 1);
                  phase <= PH_PULSE;
               end
               PH_PULSE: begin
                  if (cnt == '0) begin
                     LCDE  <= 1'b0;
                     phase <= PH_HOLD;
                  end else begin
                     cnt <= cnt - CNT_W'(1);
                  end
               end
               PH_HOLD: begin
                  if (single || second) begin
                     cnt   <= CNT_W'(item_wait - 1);
                     phase <= PH_WAIT;
                  end else begin
                     second         <= 1'b1;
                     phase          <= PH_SETUP;
                     {LCDRS, LCDAT} <= nibble_of(state, step, 1'b1);
                  end
               end
               default: cnt <= cnt - CNT_W'(1);
            endcase
         end
      end
   end

endmodule
